// File: rtl/bus_compare_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_compare_ctrl
//  Description : Sequencer for the dual-channel bus comparator. Accepts one
//                word from each redundant channel, aligns the pair within a
//                bounded skew window, compares it and reports match, mismatch
//                or timeout. Latches a safety fault after ERR_LIMIT
//                consecutive error events.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_compare_ctrl #(
    parameter int DATA_W    = 32,
    parameter int SKEW_MAX  = 15,
    parameter int ERR_LIMIT = 3,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmp_en,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              fault_clr,
    output logic              match_pulse,
    output logic              mismatch_pulse,
    output logic              timeout_pulse,
    output logic [DATA_W-1:0] mm_xor,
    output logic              fault,
    output logic [CNT_W-1:0]  err_cnt
);

    // Skew counter only needs to reach SKEW_MAX-1 (cycles already waited).
    localparam int c_skew_w   = $clog2(SKEW_MAX + 1);
    // Consecutive-error counter holds 0..ERR_LIMIT.
    localparam int c_consec_w = $clog2(ERR_LIMIT + 1);

    localparam logic [c_skew_w-1:0]   c_skew_last = c_skew_w'(SKEW_MAX - 1);
    localparam logic [c_consec_w-1:0] c_err_limit = c_consec_w'(ERR_LIMIT);
    localparam logic [CNT_W-1:0]      c_cnt_max   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_A  = 3'd1,
        S_WAIT_B  = 3'd2,
        S_COMPARE = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [c_skew_w-1:0]   skew_q, skew_d;
    logic [c_consec_w-1:0] consec_q, consec_d;
    logic [DATA_W-1:0]   a_hold_q, a_hold_d;
    logic [DATA_W-1:0]   b_hold_q, b_hold_d;
    logic [DATA_W-1:0]   mm_xor_q, mm_xor_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic                match_q, match_d;
    logic                mismatch_q, mismatch_d;
    logic                timeout_q, timeout_d;

    logic                w_a_hs;
    logic                w_b_hs;
    logic                w_err_event;

    // Ready decode from the current state; both forced low while in reset.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    a_ready = cmp_en;
                    b_ready = cmp_en;
                end
                S_WAIT_A: a_ready = 1'b1;
                S_WAIT_B: b_ready = 1'b1;
                default: begin
                    a_ready = 1'b0;
                    b_ready = 1'b0;
                end
            endcase
        end
    end

    assign w_a_hs = a_valid & a_ready;
    assign w_b_hs = b_valid & b_ready;

    // Next-state, holding registers, result pulses and error bookkeeping.
    always_comb begin
        state_d     = state_q;
        skew_d      = skew_q;
        consec_d    = consec_q;
        a_hold_d    = a_hold_q;
        b_hold_d    = b_hold_q;
        mm_xor_d    = mm_xor_q;
        err_cnt_d   = err_cnt_q;
        match_d     = 1'b0;
        mismatch_d  = 1'b0;
        timeout_d   = 1'b0;
        w_err_event = 1'b0;

        case (state_q)
            S_IDLE: begin
                skew_d = '0;
                if (w_a_hs) a_hold_d = a_data;
                if (w_b_hs) b_hold_d = b_data;
                if (w_a_hs && w_b_hs)  state_d = S_COMPARE;
                else if (w_a_hs)       state_d = S_WAIT_B;
                else if (w_b_hs)       state_d = S_WAIT_A;
            end
            S_WAIT_B: begin
                // Dropping the enable abandons the half-received pair silently.
                if (!cmp_en) begin
                    state_d = S_IDLE;
                end else if (w_b_hs) begin
                    // Arrival on the last allowed cycle still wins over expiry.
                    b_hold_d = b_data;
                    state_d  = S_COMPARE;
                end else if (skew_q == c_skew_last) begin
                    timeout_d   = 1'b1;
                    w_err_event = 1'b1;
                end else begin
                    skew_d = skew_q + c_skew_w'(1);
                end
            end
            S_WAIT_A: begin
                if (!cmp_en) begin
                    state_d = S_IDLE;
                end else if (w_a_hs) begin
                    a_hold_d = a_data;
                    state_d  = S_COMPARE;
                end else if (skew_q == c_skew_last) begin
                    timeout_d   = 1'b1;
                    w_err_event = 1'b1;
                end else begin
                    skew_d = skew_q + c_skew_w'(1);
                end
            end
            S_COMPARE: begin
                if (a_hold_q == b_hold_q) begin
                    match_d  = 1'b1;
                    consec_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    mismatch_d  = 1'b1;
                    mm_xor_d    = a_hold_q ^ b_hold_q;
                    w_err_event = 1'b1;
                end
            end
            S_FAULT: begin
                if (fault_clr) begin
                    consec_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Mismatch and timeout share the counting and the fault decision.
        if (w_err_event) begin
            if (err_cnt_q != c_cnt_max) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            consec_d = consec_q + c_consec_w'(1);
            state_d  = (consec_d == c_err_limit) ? S_FAULT : S_IDLE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            skew_q     <= '0;
            consec_q   <= '0;
            a_hold_q   <= '0;
            b_hold_q   <= '0;
            mm_xor_q   <= '0;
            err_cnt_q  <= '0;
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            skew_q     <= skew_d;
            consec_q   <= consec_d;
            a_hold_q   <= a_hold_d;
            b_hold_q   <= b_hold_d;
            mm_xor_q   <= mm_xor_d;
            err_cnt_q  <= err_cnt_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            timeout_q  <= timeout_d;
        end
    end

    assign match_pulse    = match_q;
    assign mismatch_pulse = mismatch_q;
    assign timeout_pulse  = timeout_q;
    assign mm_xor         = mm_xor_q;
    assign err_cnt        = err_cnt_q;
    assign fault          = (state_q == S_FAULT);

endmodule
`default_nettype wire
